branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the pipelined MIPS core: direct-mapped branch target buffer (BTB) with per-entry saturating direction counters, parametrised in depth, counter width and address width.
- Looked up combinationally with the fetch-stage PC to steer the next PC.
- Updated from the stage that resolves branches (E or M).
- Adds branch prediction and statistics counters, which the current core does not have (it resolves branches late and always fetches PC+4).

Parameters:
- XLEN, 32, address/data width
- ENTRIES, 16, BTB entries; power of two, ≥2
- CNT_W, 2, direction counter width; ≥1
- TAG_W, XLEN-2-$clog2(ENTRIES), stored tag bits (derived; do not override)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pcF  in  XLEN  fetch PC to look up
- pred_hit  out  1  valid entry with matching tag for pcF
- pred_taken  out  1  predicted taken (pred_hit & counter MSB)
- pred_target  out  XLEN  predicted target; 0 when !pred_hit
- upd_valid  in  1  a branch resolved this cycle
- upd_pc  in  XLEN  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target (PCBranch)
- upd_mispredict  in  1  pipeline flushed for this branch
- clear  in  1  synchronous invalidate-all
- stat_branches  out  XLEN  resolved-branch count, saturating
- stat_mispredicts  out  XLEN  mispredict count, saturating

Behaviour:
- Indexing: idx = pc[IDX_W+1:2], where IDX_W = $clog2(ENTRIES); tag = pc[XLEN-1:IDX_W+2]. PC bits [1:0] are ignored.
- Entry fields: valid, tag, target, ctr[CNT_W-1:0].
- Lookup is purely combinational (0-cycle latency) from pcF and current table state.
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & ctr[CNT_W-1].
  - pred_target = hit ? target : 0.
- Update occurs at the clk edge when upd_valid:
  - Hit, taken: ctr saturating-increments (caps at 2^CNT_W-1); target <= upd_target.
  - Hit, not taken: ctr saturating-decrements (floors at 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag, target, ctr = 2^(CNT_W-1) (weakly taken); the previous occupant is overwritten.
  - Miss, not taken: no table change.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents (no write-through bypass).
- Stats:
  - When upd_valid, stat_branches increments by 1.
  - When upd_valid & upd_mispredict, stat_mispredicts increments by 1.
  - Both hold at all-ones (no wrap).
  - upd_mispredict is ignored when upd_valid=0.
- clear (synchronous): all valid <= 0 and all ctr <= 2^(CNT_W-1)-1 (weakly not-taken). Stats are unchanged.
  - clear has priority over a same-cycle update; that update is dropped, but stats still count it.
- reset (asynchronous, any time, including mid-update): all valid=0, ctr = 2^(CNT_W-1)-1, target=0, tag=0, stats=0.
  - Outputs go immediately to pred_hit=0, pred_taken=0, pred_target=0.
  - The first clk edge after reset deasserts performs normal updates.
- CNT_W=1 degenerates to last-outcome prediction: allocate ctr=1; reset/clear ctr=0.

Decomposition:
- Package bp_pkg:
  - bp_entry_t struct {valid, tag, target, ctr}, parametrised via localparams or typedef in a parametrised class
  - functions idx_of(pc), tag_of(pc)
  - constants CTR_WEAK_T, CTR_WEAK_NT
- Sub-module bp_sat_counter: CNT_W-bit saturating up/down next-value logic, combinational, instantiated on the update path only.
- Table storage is flops (not RAM), required for reset/clear of all entries.

Test Plan:
- Reset then lookup pcF=0x0040_0010 -> pred_hit=0, pred_taken=0, pred_target=0; stats=0.
- Update upd_pc=0x0040_0010, taken, target 0x0040_0040, mispredict=1; next cycle lookup same PC -> hit=1, taken=1, target=0x0040_0040; stat_branches=1, stat_mispredicts=1.
- Counter saturation and hysteresis, from the previous state (ctr=2):
  - Two more taken updates -> ctr=3.
  - One not-taken update -> pred_taken stays 1.
  - A second not-taken update -> pred_taken=0; pred_hit stays 1.
- Aliasing (ENTRIES=16): allocate 0x0040_0010, then taken update at 0x0040_0050 (same idx, different tag) -> lookup 0x0040_0010 misses; 0x0040_0050 hits with the new target.
- Same-cycle update and lookup on the same index -> lookup shows old state that cycle, new state next cycle. Also: clear asserted together with upd_valid -> table empty afterwards, stat_branches still +1.
- Force stat counters to all-ones (XLEN=8 build, 300 updates) -> stays 0xFF. Async reset asserted between clock edges mid-sequence -> outputs clear without a clk edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: PC field extraction and the
// weak-taken / weak-not-taken counter encodings.
package bp_pkg;

    // PCs are widened to 64 bits before extraction so one helper serves every XLEN.
    function automatic logic [63:0] idx_of(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

    function automatic int unsigned ctr_weak_t(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    function automatic int unsigned ctr_weak_nt(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a CNT_W-bit saturating up/down direction counter.
module bp_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] ctr_i,
    input  logic             up_i,
    output logic [CNT_W-1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (up_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + CNT_W'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, combinational
// lookup from the fetch PC, resolved-branch update and saturating statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int ENTRIES = 16,
    parameter  int CNT_W   = 2,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = XLEN - 2 - IDX_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pcF,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            clear,
    output logic [XLEN-1:0] stat_branches,
    output logic [XLEN-1:0] stat_mispredicts
);

    localparam logic [CNT_W-1:0] CTR_WEAK_T  = CNT_W'(ctr_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] CTR_WEAK_NT = CNT_W'(ctr_weak_nt(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CNT_W-1:0] ctr;
    } bp_entry_t;

    bp_entry_t table_q [ENTRIES];
    bp_entry_t table_d [ENTRIES];
    logic [XLEN-1:0] branches_q, branches_d;
    logic [XLEN-1:0] mispred_q, mispred_d;

    logic [IDX_W-1:0] idx_f, idx_u;
    logic [TAG_W-1:0] tag_f, tag_u;
    bp_entry_t        ent_f, ent_u;
    logic             upd_hit;
    logic [CNT_W-1:0] ctr_nx;

    assign idx_f = IDX_W'(idx_of(64'(pcF), IDX_W));
    assign tag_f = TAG_W'(tag_of(64'(pcF), IDX_W));
    assign idx_u = IDX_W'(idx_of(64'(upd_pc), IDX_W));
    assign tag_u = TAG_W'(tag_of(64'(upd_pc), IDX_W));

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign ent_f       = table_q[idx_f];
    assign pred_hit    = ent_f.valid && (ent_f.tag == tag_f);
    assign pred_taken  = pred_hit && ent_f.ctr[CNT_W-1];
    assign pred_target = pred_hit ? ent_f.target : '0;

    assign ent_u   = table_q[idx_u];
    assign upd_hit = ent_u.valid && (ent_u.tag == tag_u);

    bp_sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .ctr_i (ent_u.ctr),
        .up_i  (upd_taken),
        .ctr_o (ctr_nx)
    );

    always_comb begin
        table_d = table_q;
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_d[i].valid = 1'b0;
                table_d[i].ctr   = CTR_WEAK_NT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                table_d[idx_u].ctr = ctr_nx;
                if (upd_taken) table_d[idx_u].target = upd_target;
            end else if (upd_taken) begin
                table_d[idx_u] = '{valid: 1'b1, tag: tag_u, target: upd_target, ctr: CTR_WEAK_T};
            end
        end
    end

    // Statistics count every resolved branch, even one dropped by a clear.
    always_comb begin
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (upd_valid && (branches_q != '1)) branches_d = branches_q + XLEN'(1);
        if (upd_valid && upd_mispredict && (mispred_q != '1)) mispred_d = mispred_q + XLEN'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
            end
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            table_q    <= table_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// corner sequences, randomized traffic against a behavioural model, XLEN=8 stats.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF, upd_pc, upd_target;
    logic        upd_valid, upd_taken, upd_mispredict, clear;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target, stat_branches, stat_mispredicts;

    logic [7:0]  pcF8, upd_pc8, upd_target8;
    logic        upd_valid8, upd_taken8, upd_mispredict8, clear8;
    logic        pred_hit8, pred_taken8;
    logic [7:0]  pred_target8, stat_branches8, stat_mispredicts8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .reset(reset), .pcF(pcF),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .clear(clear),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor #(.XLEN(8)) dut8 (
        .clk(clk), .reset(reset), .pcF(pcF8),
        .pred_hit(pred_hit8), .pred_taken(pred_taken8), .pred_target(pred_target8),
        .upd_valid(upd_valid8), .upd_pc(upd_pc8), .upd_taken(upd_taken8),
        .upd_target(upd_target8), .upd_mispredict(upd_mispredict8), .clear(clear8),
        .stat_branches(stat_branches8), .stat_mispredicts(stat_mispredicts8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: 16 entries, 2-bit counters, held as plain integers.
    int unsigned m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int unsigned m_ctr   [16];
    int unsigned m_br, m_mis;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_mis = 0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic h, output logic t,
                                     output logic [31:0] g);
        int unsigned i = (pc / 4) % 16;
        h = (m_valid[i] == 1) && (m_tag[i] == pc / 64);
        t = h && (m_ctr[i] >= 2);
        g = h ? m_tgt[i] : 32'd0;
    endfunction

    function automatic void m_clock(input logic v, input logic [31:0] pc, input logic t,
                                    input logic [31:0] tgt, input logic mis, input logic clr);
        int unsigned i = (pc / 4) % 16;
        logic h = (m_valid[i] == 1) && (m_tag[i] == pc / 64);
        if (v && m_br != 32'hFFFF_FFFF) m_br++;
        if (v && mis && m_mis != 32'hFFFF_FFFF) m_mis++;
        if (clr) begin
            for (int k = 0; k < 16; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
        end else if (v) begin
            if (h && t) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else if (h) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else if (t) begin
                m_valid[i] = 1; m_tag[i] = pc / 64; m_tgt[i] = tgt; m_ctr[i] = 2;
            end
        end
    endfunction

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        clr;
        logic [31:0] lpc;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
        logic [31:0] ebr;
        logic [31:0] emis;
    } vec_t;

    vec_t vecs [9];

    // Drive one update, clock it, then look up lpc against the post-edge state.
    task automatic apply_vec(input vec_t v, input int n);
        upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
        upd_mispredict = v.um; clear = v.clr; pcF = v.lpc;
        @(posedge clk);
        m_clock(v.uv, v.upc, v.ut, v.utgt, v.um, v.clr);
        #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0; clear = 1'b0;
        #1;
        chk($sformatf("vec%0d_hit", n), 32'(pred_hit), 32'(v.eh));
        chk($sformatf("vec%0d_taken", n), 32'(pred_taken), 32'(v.et));
        chk($sformatf("vec%0d_target", n), pred_target, v.etgt);
        chk($sformatf("vec%0d_branches", n), stat_branches, v.ebr);
        chk($sformatf("vec%0d_mispredicts", n), stat_mispredicts, v.emis);
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic eh,
                        input logic et, input logic [31:0] etgt);
        pcF = pc;
        #1;
        chk({nm, "_hit"}, 32'(pred_hit), 32'(eh));
        chk({nm, "_taken"}, 32'(pred_taken), 32'(et));
        chk({nm, "_target"}, pred_target, etgt);
    endtask

    logic        mh, mt;
    logic [31:0] mg;

    initial begin
        vecs[0] = '{1, 32'h0040_0010, 1, 32'h0040_0040, 1, 0, 32'h0040_0010, 1, 1, 32'h0040_0040, 1, 1};
        vecs[1] = '{1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0, 32'h0040_0010, 1, 1, 32'h0040_0040, 2, 1};
        vecs[2] = '{1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0, 32'h0040_0010, 1, 1, 32'h0040_0040, 3, 1};
        vecs[3] = '{1, 32'h0040_0010, 0, 32'h0040_0014, 1, 0, 32'h0040_0010, 1, 1, 32'h0040_0040, 4, 2};
        vecs[4] = '{1, 32'h0040_0010, 0, 32'h0040_0014, 0, 0, 32'h0040_0010, 1, 0, 32'h0040_0040, 5, 2};
        vecs[5] = '{1, 32'h0040_0050, 1, 32'h0040_0080, 1, 0, 32'h0040_0010, 0, 0, 32'h0000_0000, 6, 3};
        vecs[6] = '{0, 32'h0040_0050, 1, 32'h0040_0090, 1, 0, 32'h0040_0050, 1, 1, 32'h0040_0080, 6, 3};
        vecs[7] = '{1, 32'h0040_0020, 0, 32'h0040_0100, 0, 0, 32'h0040_0020, 0, 0, 32'h0000_0000, 7, 3};
        vecs[8] = '{1, 32'h0040_0050, 1, 32'h0040_0090, 0, 0, 32'h0040_0050, 1, 1, 32'h0040_0090, 8, 3};

        reset = 1'b1;
        pcF = 32'h0040_0010; upd_pc = '0; upd_target = '0;
        upd_valid = 0; upd_taken = 0; upd_mispredict = 0; clear = 0;
        pcF8 = '0; upd_pc8 = '0; upd_target8 = '0;
        upd_valid8 = 0; upd_taken8 = 0; upd_mispredict8 = 0; clear8 = 0;
        m_reset();
        #22;
        look("reset", 32'h0040_0010, 0, 0, 32'h0);
        chk("reset_branches", stat_branches, 32'd0);
        chk("reset_mispredicts", stat_mispredicts, 32'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        for (int n = 0; n < 9; n++) apply_vec(vecs[n], n);

        // Same-cycle update and lookup on index 4: old contents now, new after the edge.
        upd_valid = 1; upd_pc = 32'h0040_0010; upd_taken = 1; upd_target = 32'h0040_0100;
        upd_mispredict = 0;
        look("same_old_a", 32'h0040_0050, 1, 1, 32'h0040_0090);
        look("same_old_b", 32'h0040_0010, 0, 0, 32'h0);
        @(posedge clk);
        m_clock(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 0);
        #1 upd_valid = 0;
        look("same_new_a", 32'h0040_0010, 1, 1, 32'h0040_0100);
        look("same_new_b", 32'h0040_0050, 0, 0, 32'h0);

        // Clear together with an update: table empties, the branch is still counted.
        upd_valid = 1; upd_pc = 32'h0040_0030; upd_taken = 1; upd_target = 32'h0040_0200;
        clear = 1;
        @(posedge clk);
        m_clock(1, 32'h0040_0030, 1, 32'h0040_0200, 0, 1);
        #1 upd_valid = 0; clear = 0;
        look("clear_upd", 32'h0040_0030, 0, 0, 32'h0);
        look("clear_old", 32'h0040_0010, 0, 0, 32'h0);
        chk("clear_branches", stat_branches, 32'd10);

        // Randomized traffic checked against the model before every edge.
        for (int n = 0; n < 400; n++) begin
            upd_valid      = 1'($urandom_range(0, 1));
            upd_pc         = 32'h0040_0000 + 32'($urandom_range(0, 63) * 4);
            upd_taken      = 1'($urandom_range(0, 1));
            upd_target     = $urandom;
            upd_mispredict = 1'($urandom_range(0, 1));
            clear          = ($urandom_range(0, 40) == 0);
            pcF = ($urandom_range(0, 3) == 0) ? upd_pc
                                               : 32'h0040_0000 + 32'($urandom_range(0, 63) * 4);
            #2;
            m_lookup(pcF, mh, mt, mg);
            chk("rand_hit", 32'(pred_hit), 32'(mh));
            chk("rand_taken", 32'(pred_taken), 32'(mt));
            chk("rand_target", pred_target, mg);
            chk("rand_branches", stat_branches, m_br);
            chk("rand_mispredicts", stat_mispredicts, m_mis);
            @(posedge clk);
            m_clock(upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, clear);
            #1;
        end

        // Asynchronous reset between edges while an update is pending.
        upd_valid = 1; upd_pc = 32'h0040_0070; upd_taken = 1; upd_target = 32'h0040_0300;
        upd_mispredict = 0; clear = 0;
        @(posedge clk);
        m_clock(1, 32'h0040_0070, 1, 32'h0040_0300, 0, 0);
        #1;
        look("pre_async", 32'h0040_0070, 1, 1, 32'h0040_0300);
        reset = 1'b1;
        #1;
        look("async", 32'h0040_0070, 0, 0, 32'h0);
        chk("async_branches", stat_branches, 32'd0);
        chk("async_mispredicts", stat_mispredicts, 32'd0);
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        m_clock(1, 32'h0040_0070, 1, 32'h0040_0300, 0, 0);
        #1 upd_valid = 0;
        look("post_reset", 32'h0040_0070, 1, 1, 32'h0040_0300);
        chk("post_reset_branches", stat_branches, 32'd1);

        // XLEN=8 build: stats saturate at 0xFF.
        upd_valid8 = 1; upd_mispredict8 = 1;
        repeat (254) @(posedge clk);
        #1;
        chk("sat8_branches_254", 32'(stat_branches8), 32'h0000_00FE);
        chk("sat8_mispredicts_254", 32'(stat_mispredicts8), 32'h0000_00FE);
        repeat (46) @(posedge clk);
        #1;
        upd_valid8 = 0; upd_mispredict8 = 0;
        chk("sat8_branches", 32'(stat_branches8), 32'h0000_00FF);
        chk("sat8_mispredicts", 32'(stat_mispredicts8), 32'h0000_00FF);
        chk("sat8_hit", 32'(pred_hit8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
